// File: rtl/alu_pkg.sv
// Shared ALU definitions: carry-in source encodings, sequencer states, and word-count normalisation.
package alu_pkg;

  localparam logic [1:0] CIN_ZERO = 2'b00;
  localparam logic [1:0] CIN_ONE  = 2'b01;
  localparam logic [1:0] CIN_FLAG = 2'b10;
  localparam logic [1:0] CIN_EXT  = 2'b11;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  // A zero or out-of-range count means a full-length operation.
  function automatic int unsigned norm_nwords(input int unsigned n, input int unsigned max_words);
    return (n == 0 || n > max_words) ? max_words : n;
  endfunction

endpackage

// File: rtl/alu_word_adder.sv
// Combinational WIDTH-bit adder with optional B inversion; shared with the main ALU datapath.
module alu_word_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff     = sub ? ~b : b;
  assign {co, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/alu_carry_sequencer.sv
// Multi-precision add/subtract sequencer, one WIDTH-bit word per beat, LSW first.
// Build option: define ZERO_FLAG_EN to add a multi-word zero_flag output.
module alu_carry_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 4,
  parameter int NW_W      = $clog2(MAX_WORDS + 1)
) (
  input  logic             MasterClock,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [1:0]       cin_sel,
  input  logic             ext_cin,
  input  logic [NW_W-1:0]  nwords,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_word,
  output logic             done,
  output logic             busy,
  output logic             carry_flag,
  input  logic             flag_we,
  input  logic             flag_d
`ifdef ZERO_FLAG_EN
  ,
  output logic             zero_flag
`endif
);

  state_t            state;
  logic              sub_q;
  logic              carry_q;
  logic [NW_W-1:0]   nw_q;
  logic [NW_W-1:0]   cnt;
  logic              cin_res;
  logic              beat;
  logic              last;
  logic              go;
  logic [WIDTH-1:0]  sum;
  logic              co;

  always_comb begin
    cin_res = 1'b0;
    case (cin_sel)
      CIN_ZERO: cin_res = 1'b0;
      CIN_ONE:  cin_res = 1'b1;
      CIN_FLAG: cin_res = carry_flag;  // registered value, so a same-cycle flag_we is not seen
      CIN_EXT:  cin_res = ext_cin;
      default:  cin_res = 1'b0;
    endcase
  end

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN);
  assign beat     = in_valid & in_ready;
  assign last     = beat && (cnt == nw_q - NW_W'(1));
  assign go       = (state == IDLE) && start;

  alu_word_adder #(.WIDTH(WIDTH)) u_add (
    .a   (a_word),
    .b   (b_word),
    .sub (sub_q),
    .cin (carry_q),
    .sum (sum),
    .co  (co)
  );

  always_ff @(posedge MasterClock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sub_q      <= 1'b0;
      carry_q    <= 1'b0;
      nw_q       <= '0;
      cnt        <= '0;
      res_valid  <= 1'b0;
      res_word   <= '0;
      done       <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      res_valid <= beat;
      done      <= last;
      if (beat) begin
        res_word <= sum;
        carry_q  <= co;
        cnt      <= cnt + NW_W'(1);
      end
      if (flag_we) carry_flag <= flag_d;
      // The last-word carry overrides a coincident direct load.
      if (last) begin
        carry_flag <= co;
        state      <= IDLE;
      end
      if (go) begin
        sub_q   <= op_sub;
        nw_q    <= NW_W'(norm_nwords(32'(nwords), 32'(MAX_WORDS)));
        carry_q <= cin_res;
        cnt     <= '0;
        state   <= RUN;
      end
    end
  end

`ifdef ZERO_FLAG_EN
  logic zacc;

  always_ff @(posedge MasterClock or posedge reset) begin
    if (reset) begin
      zacc      <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      if (beat) zacc <= zacc & (sum == '0);
      if (last) zero_flag <= zacc & (sum == '0);
      if (go)   zacc <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_carry_sequencer.sv
// Self-checking bench for alu_carry_sequencer (WIDTH=8, MAX_WORDS=4): directed table, corner sequences, random ops.
module tb_alu_carry_sequencer;

  localparam int W = 8;
  localparam int MW = 4;
  localparam int NWW = 3;

  logic MasterClock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, op_sub = 1'b0, ext_cin = 1'b0, in_valid = 1'b0;
  logic flag_we = 1'b0, flag_d = 1'b0;
  logic [1:0] cin_sel = 2'b00;
  logic [NWW-1:0] nwords = '0;
  logic [W-1:0] a_word = '0, b_word = '0;
  logic in_ready, res_valid, done, busy, carry_flag;
  logic [W-1:0] res_word;
`ifdef ZERO_FLAG_EN
  logic zero_flag;
`endif

  int total = 0;
  int bad = 0;
  logic mflag = 1'b0;

  always #5 MasterClock = ~MasterClock;

  alu_carry_sequencer #(.WIDTH(W), .MAX_WORDS(MW)) dut (
    .MasterClock(MasterClock), .reset(reset), .start(start), .op_sub(op_sub),
    .cin_sel(cin_sel), .ext_cin(ext_cin), .nwords(nwords), .in_valid(in_valid),
    .in_ready(in_ready), .a_word(a_word), .b_word(b_word), .res_valid(res_valid),
    .res_word(res_word), .done(done), .busy(busy), .carry_flag(carry_flag),
    .flag_we(flag_we), .flag_d(flag_d)
`ifdef ZERO_FLAG_EN
    , .zero_flag(zero_flag)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge MasterClock);
    #1;
  endtask

  typedef struct {
    logic        sub;
    logic [1:0]  cs;
    logic        ec;
    logic [2:0]  nw;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] er;
    logic        ef;
    logic        ez;
    int          gap_at;
    int          gap_len;
    logic        ws;
    logic        wl;
    logic        sm;
  } vec_t;

  // One complete operation: start cycle, beats (optional stall), result/flag checks.
  task automatic do_op(input vec_t v);
    int n;
    logic [W-1:0] prev;
    n = (v.nw == 0 || v.nw > MW) ? MW : int'(v.nw);
    start = 1'b1; op_sub = v.sub; cin_sel = v.cs; ext_cin = v.ec; nwords = v.nw;
    if (v.ws) begin flag_we = 1'b1; flag_d = ~mflag; end
    tick();
    start = 1'b0; flag_we = 1'b0; nwords = '0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("ready_after_start", 32'(in_ready), 32'd1);
    prev = res_word;
    for (int i = 0; i < n; i++) begin
      if (i == v.gap_at) begin
        for (int g = 0; g < v.gap_len; g++) begin
          in_valid = 1'b0;
          tick();
          check("gap_res_valid", 32'(res_valid), 32'd0);
          check("gap_done", 32'(done), 32'd0);
          check("gap_res_hold", 32'(res_word), 32'(prev));
        end
      end
      in_valid = 1'b1; a_word = v.a[8*i +: 8]; b_word = v.b[8*i +: 8];
      if (v.sm && i == 0) begin start = 1'b1; nwords = 3'd1; end
      if (v.wl && i == n - 1) begin flag_we = 1'b1; flag_d = 1'b1; end
      tick();
      in_valid = 1'b0; start = 1'b0; flag_we = 1'b0; nwords = '0;
      check("res_valid", 32'(res_valid), 32'd1);
      check("res_word", 32'(res_word), 32'(v.er[8*i +: 8]));
      check("done", 32'(done), (i == n - 1) ? 32'd1 : 32'd0);
      prev = res_word;
    end
    check("carry_flag", 32'(carry_flag), 32'(v.ef));
    check("idle_after_op", 32'(busy), 32'd0);
`ifdef ZERO_FLAG_EN
    check("zero_flag", 32'(zero_flag), 32'(v.ez));
`endif
    mflag = v.ef;
  endtask

  // Whole-operand arithmetic model: result is the low n*W bits, carry the next bit up.
  task automatic model(inout vec_t v);
    int n;
    logic [63:0] mask, bb, tot;
    logic cin_v;
    n = (v.nw == 0 || v.nw > MW) ? MW : int'(v.nw);
    mask = (64'd1 << (W * n)) - 64'd1;
    cin_v = (v.cs == 2'd0) ? 1'b0 : (v.cs == 2'd1) ? 1'b1 : (v.cs == 2'd2) ? mflag : v.ec;
    bb = v.sub ? (~{32'd0, v.b} & mask) : ({32'd0, v.b} & mask);
    tot = ({32'd0, v.a} & mask) + bb + {63'd0, cin_v};
    v.er = tot[31:0] & mask[31:0];
    v.ef = tot[W * n];
    v.ez = ((tot & mask) == 64'd0);
  endtask

  vec_t tbl[12];

  initial begin
    //          sub  cs    ec    nw    a             b             er            ef    ez    gap  len ws    wl    sm
    tbl[0]  = '{1'b0, 2'd0, 1'b0, 3'd2, 32'h000001FF, 32'h00000001, 32'h00000200, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'd1, 1'b0, 3'd1, 32'h00000005, 32'h00000007, 32'h000000FE, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 2'd1, 1'b0, 3'd1, 32'h00000007, 32'h00000005, 32'h00000002, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 3'd1, 32'h000000FF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 3'd1, 32'h00000000, 32'h00000000, 32'h00000001, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 3'd0, 32'h11223344, 32'h01010101, 32'h12233445, 1'b0, 1'b0,  2, 3, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 2'd3, 1'b1, 3'd3, 32'h0000FFFF, 32'h00000000, 32'h00010000, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 2'd1, 1'b0, 3'd2, 32'h00000100, 32'h00000100, 32'h00000000, 1'b1, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 2'd1, 1'b0, 3'd2, 32'h00000100, 32'h000000FF, 32'h00000001, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0};
    // flag is 1 here; a coincident load of 0 must not change the carry-in
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 3'd1, 32'h00000000, 32'h00000000, 32'h00000001, 1'b0, 1'b0, -1, 0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 3'd1, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0, -1, 0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 2'd0, 1'b0, 3'd2, 32'h00000203, 32'h00000101, 32'h00000304, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, 1'b1};

    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_word", 32'(res_word), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_carry_flag", 32'(carry_flag), 32'd0);
    #10 reset = 1'b0;
    tick();

    // in_valid while idle must not produce results
    in_valid = 1'b1; a_word = 8'h12; b_word = 8'h34;
    tick();
    check("idle_ready", 32'(in_ready), 32'd0);
    tick();
    check("idle_res_valid", 32'(res_valid), 32'd0);
    in_valid = 1'b0;

    for (int i = 0; i < 12; i++) do_op(tbl[i]);

    // direct flag load in IDLE
    flag_we = 1'b1; flag_d = 1'b1;
    tick();
    flag_we = 1'b0;
    check("flag_load_idle", 32'(carry_flag), 32'd1);
    mflag = 1'b1;

    // reset mid-operation
    start = 1'b1; cin_sel = 2'd0; op_sub = 1'b0; nwords = 3'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1; a_word = 8'h10; b_word = 8'h20;
    tick();
    reset = 1'b1;
    #1;
    check("abort_res_valid", 32'(res_valid), 32'd0);
    check("abort_res_word", 32'(res_word), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_flag", 32'(carry_flag), 32'd0);
    tick();
    reset = 1'b0;
    mflag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_no_res", 32'(res_valid), 32'd0);
    end
    in_valid = 1'b0;

    for (int r = 0; r < 40; r++) begin
      vec_t v;
      v.sub = 1'($urandom_range(0, 1));
      v.cs = 2'($urandom_range(0, 3));
      v.ec = 1'($urandom_range(0, 1));
      v.nw = 3'($urandom_range(0, 7));
      v.a = $urandom;
      v.b = (r % 5 == 0) ? v.a : $urandom;
      v.gap_at = $urandom_range(0, 5);
      v.gap_len = $urandom_range(0, 2);
      v.ws = 1'b0; v.wl = 1'b0; v.sm = 1'b0;
      model(v);
      do_op(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
